// File: rtl/fetch_pkg.sv
// Shared definitions for the prefetching fetch stage: PC step, FSM states
// and the width helper for queue/outstanding counters.
package fetch_pkg;

  localparam int PC_STEP = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // One extra bit so a counter can hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {instruction, pc} entries; flush empties it in one
// cycle and overrides any push/pop presented in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: in-order imem requests, DEPTH-entry response queue,
// redirect flush with stale-response dropping. FETCH_STATS_EN adds counters.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped,
`endif
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CW = cnt_w(DEPTH);
  localparam int FW = DATA_W + ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

  logic [ADDR_W-1:0] target_pc;
  logic [CW:0]       in_use;
  logic              accept, push, pop;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign target_pc = redirect_pc & ~ADDR_W'(PC_STEP - 1);
  // Queue slots plus in-flight responses may never exceed DEPTH, so every response has a home.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req  = reset && !redirect && !fifo_full && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_gnt;
  assign push      = imem_rvalid && (state_q == RUN) && !redirect;

  assign instr_valid = reset && !fifo_empty && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign instr       = fifo_empty ? '0 : fifo_rdata[FW-1:ADDR_W];
  assign instr_pc    = fifo_empty ? '0 : fifo_rdata[ADDR_W-1:0];

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, rsp_pc_q}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
    fetch_pc_d    = accept ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    rsp_pc_d      = push ? rsp_pc_q + ADDR_W'(PC_STEP) : rsp_pc_q;
    if (redirect) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
      state_d    = (drop_cnt_d != '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        FLUSH: begin
          if (imem_rvalid) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_dropped_q, stat_dropped_d;
  logic [32:0] dropped_sum;

  // A discard is any response not pushed, plus every entry wiped by a redirect.
  always_comb begin
    dropped_sum    = {1'b0, stat_dropped_q} + 33'(imem_rvalid && !push)
                     + (redirect ? 33'(fifo_count) : 33'd0);
    stat_dropped_d = dropped_sum[32] ? '1 : dropped_sum[31:0];
    stat_fetched_d = stat_fetched_q;
    if (pop && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule
